// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor
// Digit-serial packed-BCD subtractor computing X - Y one decimal digit per
// clock, least significant digit first, with a start/done handshake.
// A single 4-bit digit slice and one borrow flop are reused for every digit.
//
// Optional feature macro: BCD_SIGN_MAGNITUDE_EN
//   defined   : a negative result is converted to its magnitude in a FIX pass
//               (ten's complement of Diff, digit-serial) and negative = 1.
//   undefined : a negative result is left as the DIGITS-digit ten's
//               complement with borrow_out = 1; negative is tied to 0.
//
// state | meaning
// IDLE  | waiting for start
// SUB   | subtracting digit idx (one cycle only when operands were invalid)
// FIX   | ten's-complementing Diff digit idx (sign-magnitude build only)
// DONE  | one-cycle done pulse, results valid
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   X,
  input  logic [4*DIGITS-1:0]   Y,
  output logic [4*DIGITS-1:0]   Diff,
  output logic                  borrow_out,
  output logic                  negative,
  output logic                  invalid,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

`ifdef BCD_SIGN_MAGNITUDE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] x_q, y_q;
  logic [IW-1:0]       idx_q;
  logic                borrow_q;
  logic                accept;
  logic                last_dig;
  logic                bad_operand;
  logic [3:0]          a_dig, b_dig, dig_res;
  logic [4:0]          t_raw;
  logic                brw_nxt;
`ifdef BCD_SIGN_MAGNITUDE_EN
  logic                negative_q;
`endif

  function automatic logic has_bad_nibble(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign accept      = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign last_dig    = (idx_q == LAST_IDX);
  assign bad_operand = has_bad_nibble(X) | has_bad_nibble(Y);

  // Shared digit slice: X_i - Y_i - b in SUB, 0 - Diff_i - b in FIX.
  always_comb begin
    a_dig = x_q[idx_q*4 +: 4];
    b_dig = y_q[idx_q*4 +: 4];
`ifdef BCD_SIGN_MAGNITUDE_EN
    if (state_q == FIX) begin
      a_dig = 4'd0;
      b_dig = Diff[idx_q*4 +: 4];
    end
`endif
    // Range is -10..9, so bit 4 is the sign of the 5-bit difference.
    t_raw   = {1'b0, a_dig} - {1'b0, b_dig} - {4'd0, borrow_q};
    brw_nxt = t_raw[4];
    dig_res = t_raw[4] ? (t_raw[3:0] + 4'd10) : t_raw[3:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; invalid operands still spend one SUB cycle so done
  // arrives one cycle after acceptance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = SUB;
      SUB: begin
        if (invalid) begin
          state_d = DONE;
        end else if (last_dig) begin
`ifdef BCD_SIGN_MAGNITUDE_EN
          state_d = brw_nxt ? FIX : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef BCD_SIGN_MAGNITUDE_EN
      FIX: if (last_dig) state_d = DONE;
`endif
      DONE: state_d = start ? SUB : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, digit-serial result accumulation and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      Diff       <= '0;
      borrow_out <= 1'b0;
      invalid    <= 1'b0;
      borrow_q   <= 1'b0;
      idx_q      <= '0;
`ifdef BCD_SIGN_MAGNITUDE_EN
      negative_q <= 1'b0;
`endif
    end else if (accept) begin
      x_q        <= X;
      y_q        <= Y;
      Diff       <= '0;
      borrow_out <= 1'b0;
      invalid    <= bad_operand;
      borrow_q   <= 1'b0;
      idx_q      <= '0;
`ifdef BCD_SIGN_MAGNITUDE_EN
      negative_q <= 1'b0;
`endif
    end else if ((state_q == SUB) && !invalid) begin
      Diff[idx_q*4 +: 4] <= dig_res;
      if (last_dig) begin
        borrow_out <= brw_nxt;
        borrow_q   <= 1'b0;
        idx_q      <= '0;
      end else begin
        borrow_q   <= brw_nxt;
        idx_q      <= idx_q + 1'b1;
      end
    end
`ifdef BCD_SIGN_MAGNITUDE_EN
    else if (state_q == FIX) begin
      Diff[idx_q*4 +: 4] <= dig_res;
      if (last_dig) begin
        negative_q <= 1'b1;
        borrow_q   <= 1'b0;
        idx_q      <= '0;
      end else begin
        borrow_q   <= brw_nxt;
        idx_q      <= idx_q + 1'b1;
      end
    end
`endif
  end

`ifdef BCD_SIGN_MAGNITUDE_EN
  assign negative = negative_q;
  assign busy     = (state_q == SUB) || (state_q == FIX);
`else
  assign negative = 1'b0;
  assign busy     = (state_q == SUB);
`endif
  assign done = (state_q == DONE);

endmodule

// File: doc/bcd_serial_subtractor.md
# bcd_serial_subtractor

Digit-serial multi-digit BCD subtractor that computes X − Y one decimal digit per clock, least significant digit first, with a start/done handshake. It is the subtraction counterpart to the combinational BCD adder and sits beside it in the adder-subtractor datapath. It trades latency for a single 4-bit digit slice and borrow flop, instead of a full-width chain.

## Interface
- DIGITS, 4: number of BCD digits per operand (≥1).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- X  input  4*DIGITS  minuend, packed BCD, digit 0 = bits [3:0].
- Y  input  4*DIGITS  subtrahend, packed BCD.
- Diff  output  4*DIGITS  result, packed BCD.
- borrow_out  output  1  final borrow out of the MSD (1 ⇔ X < Y).
- negative  output  1  Diff is a magnitude of a negative result (macro build only; else 0).
- invalid  output  1  some operand nibble > 9 at acceptance.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: results valid.

## Operation
- States: IDLE, SUB, FIX (macro only), DONE.
- IDLE/DONE with start=1: latch X, Y; clear Diff, borrow_out, negative, invalid; borrow := 0; digit index := 0.
  - Any nibble of X or Y > 9 → invalid := 1, go to DONE (no arithmetic; Diff stays 0).
  - Otherwise go to SUB.
- SUB, per edge on digit i: t = X_i − Y_i − borrow. If t < 0: Diff_i := t + 10, borrow := 1; else Diff_i := t, borrow := 0. Index increments.
- Done with the last digit: borrow_out := final borrow. If the macro is enabled and the final borrow = 1, go to FIX; otherwise go to DONE.
- FIX (macro): ten's complement of Diff in place, digit-serial LSD first: t = 0 − Diff_i − b, same correction rule. negative := 1, then DONE.
- DONE lasts one cycle: done=1, busy=0, then IDLE unless start is accepted.
- Diff, borrow_out, negative and invalid hold from DONE until the next accepted start.
- start while busy (SUB/FIX): ignored, no queuing.
- Equal operands: Diff = 0, borrow_out = 0, negative = 0.

## Timing
- Reset (async, any state, including mid-operation): state IDLE. Diff, borrow_out, negative, invalid, busy and done all = 0. Internal borrow and index = 0.
- Edge E0 samples start; busy = 1 from after E0 through the last SUB/FIX edge.
- Normal: digit i processed at edge E(i+1). State DONE after E(DIGITS); done high for the cycle after E(DIGITS). Latency = DIGITS cycles.
- Macro and negative: FIX digits at E(DIGITS+1)..E(2·DIGITS); done after E(2·DIGITS).
- Invalid: done after E1.
- Back-to-back: start high during the DONE cycle is accepted at that edge; done stays a one-cycle pulse.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- BCD_SIGN_MAGNITUDE_EN defined: FIX state is present. A negative result is returned as magnitude |X − Y| with negative = 1, at up to 2·DIGITS latency.
- Not defined: no FIX state and negative is tied to 0. A negative result is left as the DIGITS-digit ten's complement, with borrow_out = 1. Latency is always DIGITS.

## Test plan
- DIGITS=4, X=5432, Y=1234, start one cycle → Diff=4198, borrow_out=0, done pulse 4 cycles after start edge, busy high 4 cycles.
- X=1000, Y=0001 → Diff=0999, borrow ripples across 3 digits, borrow_out=0.
- X=0001, Y=0002 → without macro: Diff=9999, borrow_out=1, negative=0, latency 4. With BCD_SIGN_MAGNITUDE_EN: Diff=0001, borrow_out=1, negative=1, latency 8.
- X=0x12A4, Y=0000 → invalid=1, Diff=0000, done after 1 cycle. Next valid start clears invalid.
- start pulsed again at cycle 2 of an operation → ignored, results match the first operands. start held through DONE → second operation accepted back-to-back.
- rst asserted at cycle 2 of SUB → immediately busy=0, Diff=0, no done pulse. A fresh start afterwards computes correctly.
